// File: rtl/traffic_fsm.sv
// rtl/traffic_fsm.sv - main/side street light sequencer with pedestrian walk phase
//
// Steps through the light phases. Each new phase selects a timer interval and
// pulses start_timer. The FSM moves on when the interval timer reports expired.
//
// Ports:
//   clk                  in   system clock, rising edge
//   sys_reset            in   asynchronous active-low reset
//   sensor_sync_in       in   side-street vehicle sensor (synchronised)
//   walkRegister_status  in   latched pedestrian walk request
//   prg_sync_in          in   reprogram strobe, restarts at MG1
//   expired              in   timer interval elapsed pulse
//   walkRegister_reset   out  pulse clearing the walk request on WALK entry
//   interval_address     out  00 tBASE, 01 tEXT, 10 tYEL
//   start_timer          out  pulse on first cycle of every entered state
//   light_signals        out  {mainR,mainY,mainG, sideR,sideY,sideG, walk}

module traffic_fsm (
   input  logic       clk,
   input  logic       sys_reset,
   input  logic       sensor_sync_in,
   input  logic       walkRegister_status,
   input  logic       prg_sync_in,
   input  logic       expired,
   output logic       walkRegister_reset,
   output logic [1:0] interval_address,
   output logic       start_timer,
   output logic [6:0] light_signals
);

   typedef enum logic [2:0] {
      MG1  = 3'd0,
      MG2  = 3'd1,
      MY   = 3'd2,
      WALK = 3'd3,
      SG1  = 3'd4,
      SG2  = 3'd5,
      SY   = 3'd6
   } state_t;

   localparam logic [6:0] LAMP_MG   = 7'b001_100_0;
   localparam logic [6:0] LAMP_MY   = 7'b010_100_0;
   localparam logic [6:0] LAMP_WALK = 7'b100_100_1;
   localparam logic [6:0] LAMP_SG   = 7'b100_001_0;
   localparam logic [6:0] LAMP_SY   = 7'b100_010_0;

   localparam logic [1:0] T_BASE = 2'b00;
   localparam logic [1:0] T_EXT  = 2'b01;
   localparam logic [1:0] T_YEL  = 2'b10;

   state_t state, state_nxt;
   logic   ext, ext_nxt;
   logic   start_nxt;
   logic   wr_nxt;
   logic   advance;

   // Reset leaves start_timer high so that the timer is loaded for MG1.
   always_ff @(posedge clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state              <= MG1;
         ext                <= 1'b0;
         start_timer        <= 1'b1;
         walkRegister_reset <= 1'b0;
      end else begin
         state              <= state_nxt;
         ext                <= ext_nxt;
         start_timer        <= start_nxt;
         walkRegister_reset <= wr_nxt;
      end
   end

   // In the start cycle the timer is being reloaded, so expired is ignored.
   // This also keeps a held-high expired from advancing twice in a row.
   assign advance = expired && !start_timer;

   always_comb begin
      state_nxt = state;
      ext_nxt   = ext;
      start_nxt = 1'b0;
      wr_nxt    = 1'b0;
      if (prg_sync_in) begin
         state_nxt = MG1;
         ext_nxt   = 1'b0;
         start_nxt = 1'b1;
      end else begin
         case (state)
            MG1: if (advance) begin
               state_nxt = MG2;
               ext_nxt   = sensor_sync_in;
               start_nxt = 1'b1;
            end
            MG2: if (advance) begin
               state_nxt = MY;
               start_nxt = 1'b1;
            end
            MY: if (advance) begin
               start_nxt = 1'b1;
               if (walkRegister_status) begin
                  state_nxt = WALK;
                  wr_nxt    = 1'b1;
               end else begin
                  state_nxt = SG1;
               end
            end
            WALK: if (advance) begin
               state_nxt = SG1;
               start_nxt = 1'b1;
            end
            SG1: if (advance) begin
               state_nxt = sensor_sync_in ? SG2 : SY;
               start_nxt = 1'b1;
            end
            SG2: if (advance) begin
               state_nxt = SY;
               start_nxt = 1'b1;
            end
            SY: if (advance) begin
               state_nxt = MG1;
               start_nxt = 1'b1;
            end
            default: begin
               // Unused code: restart the sequence from MG1.
               state_nxt = MG1;
               ext_nxt   = 1'b0;
               start_nxt = 1'b1;
            end
         endcase
      end
   end

   // Lamps and interval are decoded from state alone, so an async reset
   // moves them straight to the MG1 values.
   always_comb begin
      light_signals    = LAMP_MG;
      interval_address = T_BASE;
      case (state)
         MG1: begin
            light_signals    = LAMP_MG;
            interval_address = T_BASE;
         end
         MG2: begin
            light_signals    = LAMP_MG;
            interval_address = ext ? T_EXT : T_BASE;
         end
         MY: begin
            light_signals    = LAMP_MY;
            interval_address = T_YEL;
         end
         WALK: begin
            light_signals    = LAMP_WALK;
            interval_address = T_EXT;
         end
         SG1: begin
            light_signals    = LAMP_SG;
            interval_address = T_BASE;
         end
         SG2: begin
            light_signals    = LAMP_SG;
            interval_address = T_EXT;
         end
         SY: begin
            light_signals    = LAMP_SY;
            interval_address = T_YEL;
         end
         default: begin
            light_signals    = LAMP_MG;
            interval_address = T_BASE;
         end
      endcase
   end

endmodule

// File: tb/tb_traffic_fsm.sv
// tb/tb_traffic_fsm.sv - directed self-checking bench for traffic_fsm

module tb_traffic_fsm;

   logic       clk;
   logic       sys_reset;
   logic       sensor_sync_in;
   logic       walkRegister_status;
   logic       prg_sync_in;
   logic       expired;
   logic       walkRegister_reset;
   logic [1:0] interval_address;
   logic       start_timer;
   logic [6:0] light_signals;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] L_MG   = 7'b0011000;
   localparam logic [6:0] L_MY   = 7'b0101000;
   localparam logic [6:0] L_WALK = 7'b1001001;
   localparam logic [6:0] L_SG   = 7'b1000010;
   localparam logic [6:0] L_SY   = 7'b1000100;

   traffic_fsm dut (
      .clk                 (clk),
      .sys_reset           (sys_reset),
      .sensor_sync_in      (sensor_sync_in),
      .walkRegister_status (walkRegister_status),
      .prg_sync_in         (prg_sync_in),
      .expired             (expired),
      .walkRegister_reset  (walkRegister_reset),
      .interval_address    (interval_address),
      .start_timer         (start_timer),
      .light_signals       (light_signals)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_expired();
      expired = 1'b1;
      step();
      expired = 1'b0;
   endtask

   // Compares {lights, addr, start_timer, walkRegister_reset} in one go.
   task automatic check(input string tag, input logic [6:0] lamps,
                        input logic [1:0] addr, input logic st, input logic wr);
      logic [10:0] obs;
      logic [10:0] exp_v;
      obs   = {light_signals, interval_address, start_timer, walkRegister_reset};
      exp_v = {lamps, addr, st, wr};
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed lights=%b addr=%b st=%b wr=%b, expected lights=%b addr=%b st=%b wr=%b",
                tag, obs[10:4], obs[3:2], obs[1], obs[0],
                exp_v[10:4], exp_v[3:2], exp_v[1], exp_v[0]);
      end
   endtask

   initial begin
      sys_reset           = 1'b1;
      sensor_sync_in      = 1'b0;
      walkRegister_status = 1'b0;
      prg_sync_in         = 1'b0;
      expired             = 1'b0;

      // 1 reset
      #1 sys_reset = 1'b0;
      #1 check("reset_async", L_MG, 2'b00, 1'b1, 1'b0);
      step();
      step();
      check("reset_held", L_MG, 2'b00, 1'b1, 1'b0);
      sys_reset = 1'b1;
      #1 check("release_start_cycle", L_MG, 2'b00, 1'b1, 1'b0);
      step();
      check("after_first_edge", L_MG, 2'b00, 1'b0, 1'b0);
      step();
      check("no_advance_idle", L_MG, 2'b00, 1'b0, 1'b0);

      // 2 plain cycle
      pulse_expired(); check("plain_mg2", L_MG, 2'b00, 1'b1, 1'b0);
      step();          check("plain_mg2_run", L_MG, 2'b00, 1'b0, 1'b0);
      pulse_expired(); check("plain_my", L_MY, 2'b10, 1'b1, 1'b0);
      step();          check("plain_my_run", L_MY, 2'b10, 1'b0, 1'b0);
      pulse_expired(); check("plain_sg1", L_SG, 2'b00, 1'b1, 1'b0);
      step();
      pulse_expired(); check("plain_sy", L_SY, 2'b10, 1'b1, 1'b0);
      step();
      pulse_expired(); check("plain_mg1", L_MG, 2'b00, 1'b1, 1'b0);
      step();          check("plain_mg1_run", L_MG, 2'b00, 1'b0, 1'b0);

      // 3 sensor extensions
      sensor_sync_in = 1'b1;
      pulse_expired(); check("ext_mg2", L_MG, 2'b01, 1'b1, 1'b0);
      sensor_sync_in = 1'b0;
      step();          check("ext_mg2_hold", L_MG, 2'b01, 1'b0, 1'b0);
      pulse_expired(); check("ext_my", L_MY, 2'b10, 1'b1, 1'b0);
      step();
      pulse_expired(); check("ext_sg1", L_SG, 2'b00, 1'b1, 1'b0);
      step();
      sensor_sync_in = 1'b1;
      pulse_expired(); check("ext_sg2", L_SG, 2'b01, 1'b1, 1'b0);
      sensor_sync_in = 1'b0;
      step();
      pulse_expired(); check("ext_sy", L_SY, 2'b10, 1'b1, 1'b0);
      step();

      // expired held high: one advance per start cycle
      expired = 1'b1;
      step();          check("held_mg1", L_MG, 2'b00, 1'b1, 1'b0);
      step();          check("held_ignored", L_MG, 2'b00, 1'b0, 1'b0);
      step();          check("held_mg2", L_MG, 2'b00, 1'b1, 1'b0);
      expired = 1'b0;
      step();

      // 4 walk phase
      pulse_expired(); check("walk_my", L_MY, 2'b10, 1'b1, 1'b0);
      step();
      walkRegister_status = 1'b1;
      pulse_expired(); check("walk_entry", L_WALK, 2'b01, 1'b1, 1'b1);
      walkRegister_status = 1'b0;
      step();          check("walk_run", L_WALK, 2'b01, 1'b0, 1'b0);
      pulse_expired(); check("walk_to_sg1", L_SG, 2'b00, 1'b1, 1'b0);
      step();
      pulse_expired(); check("walk_sy", L_SY, 2'b10, 1'b1, 1'b0);
      step();

      // 5 prg together with expired while in SY
      prg_sync_in = 1'b1;
      expired     = 1'b1;
      step();          check("prg_mg1", L_MG, 2'b00, 1'b1, 1'b0);
      prg_sync_in = 1'b0;
      step();          check("prg_start_ignores_exp", L_MG, 2'b00, 1'b0, 1'b0);
      expired = 1'b0;
      step();          check("prg_settled", L_MG, 2'b00, 1'b0, 1'b0);

      // prg held restarts every edge; also clears ext
      sensor_sync_in = 1'b1;
      pulse_expired(); check("prg_ext_set", L_MG, 2'b01, 1'b1, 1'b0);
      sensor_sync_in = 1'b0;
      step();
      prg_sync_in = 1'b1;
      step();          check("prg_held_1", L_MG, 2'b00, 1'b1, 1'b0);
      step();          check("prg_held_2", L_MG, 2'b00, 1'b1, 1'b0);
      prg_sync_in = 1'b0;
      step();          check("prg_released", L_MG, 2'b00, 1'b0, 1'b0);
      pulse_expired(); check("prg_ext_cleared", L_MG, 2'b00, 1'b1, 1'b0);
      step();

      // 6 async reset while in WALK
      pulse_expired(); check("rst_my", L_MY, 2'b10, 1'b1, 1'b0);
      step();
      walkRegister_status = 1'b1;
      pulse_expired();
      walkRegister_status = 1'b0;
      step();          check("rst_in_walk", L_WALK, 2'b01, 1'b0, 1'b0);
      #2 sys_reset = 1'b0;
      #1 check("rst_mid_walk", L_MG, 2'b00, 1'b1, 1'b0);
      step();
      sys_reset = 1'b1;
      step();          check("rst_recovered", L_MG, 2'b00, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
